triangle_sequencer: RTL and testbench
=====================================

TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the triangle-list memory address width.
REQ-002 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to render a triangle list; sampled only in IDLE.
REQ-005 The block SHALL have port base_addr, input, ADDR_W, first list entry; sampled on accepted start.
REQ-006 The block SHALL have port tri_count, input, ADDR_W+1, number of entries; sampled on accepted start.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W, list memory read address.
REQ-008 The block SHALL have port mem_rd, output, 1, list memory read strobe.
REQ-009 The block SHALL have port mem_data, input, 51, entry returned exactly one cycle after mem_rd; layout [50:48] colour, [47:40] ax, [39:32] ay, [31:24] bx, [23:16] by, [15:8] cx, [7:0] cy.
REQ-010 The block SHALL have ports ax, ay, bx, by, cx, cy, output, 8 each, registered vertices to the rasterizer.
REQ-011 The block SHALL have port colour, output, 3, registered fill colour to the rasterizer.
REQ-012 The block SHALL have port draw_en, output, 1, one-cycle rasterizer start pulse.
REQ-013 The block SHALL have port draw_done, input, 1, rasterizer idle flag (high when idle, low while drawing).
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse when the list completes.
REQ-016 The block SHALL have port tri_index, output, ADDR_W+1, number of triangles fully drawn in the current list.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, LATCH, ISSUE, ARM, WAIT, FINISH.
REQ-018 IDLE: start=1 with tri_count=0 SHALL go to FINISH; start=1 with tri_count>0 SHALL capture base_addr/tri_count, clear tri_index and go to FETCH; otherwise stay.
REQ-019 FETCH SHALL assert mem_rd=1 with mem_addr=current address for exactly one cycle, then go to LATCH.
REQ-020 LATCH SHALL register all mem_data fields into ax..cy and colour, then go to ISSUE.
REQ-021 ISSUE SHALL assert draw_en=1 for exactly one cycle, then go to ARM.
REQ-022 ARM SHALL ignore draw_done for one cycle (rasterizer still reporting idle), then go to WAIT.
REQ-023 WAIT SHALL hold until draw_done=1, then increment tri_index and the address (modulo 2^ADDR_W, wrap from max to 0); if incremented tri_index equals captured count go to FINISH, else FETCH.
REQ-024 FINISH SHALL assert done=1 for one cycle, then go to IDLE.
REQ-025 Vertex and colour outputs SHALL change only in LATCH and SHALL hold stable through ISSUE, ARM and WAIT.
REQ-026 start while busy=1 SHALL be ignored; changes on base_addr/tri_count after acceptance SHALL have no effect.
REQ-027 mem_rd SHALL be 0 outside FETCH; draw_en SHALL be 0 outside ISSUE.
REQ-028 Per-triangle overhead SHALL be 4 cycles (FETCH, LATCH, ISSUE, ARM) plus WAIT duration.
REQ-029 tri_index SHALL hold its final value after FINISH until the next accepted start.

Reset
REQ-030 resetn=0 at a rising edge SHALL force IDLE from any state, including mid-draw, in the same edge.
REQ-031 During and after reset: busy=0, done=0, draw_en=0, mem_rd=0, mem_addr=0, tri_index=0, ax..cy=0, colour=0.
REQ-032 Reset SHALL NOT wait for draw_done; the rasterizer shares resetn and returns to idle together.

Verification
REQ-033 start, base_addr=5, tri_count=1, entry {colour=3, a=(10,10), b=(20,10), c=(10,20)}, draw_done low 7 cycles after ARM -> mem_rd at addr 5, draw_en one pulse, vertices stable, done pulse, tri_index=1.
REQ-034 start, tri_count=0 -> done pulses two cycles after start, no mem_rd, no draw_en, tri_index=0.
REQ-035 start, base_addr=62, tri_count=3, ADDR_W=6 -> reads addresses 62, 63, 0 in order, three draw_en pulses, tri_index=3 at done.
REQ-036 start asserted again during WAIT of a 2-entry list -> ignored; exactly 2 draw_en pulses, one done.
REQ-037 resetn=0 during WAIT of entry 2 of 4 -> next cycle all outputs at reset values; subsequent start with tri_count=1 runs normally.
REQ-038 Integrated with the rasterizer, triangle (0,0),(3,0),(0,3) -> sequencer stays in WAIT for the full grid scan and done follows draw_done high by one FINISH cycle.

Source files
------------

// File: rtl/triangle_sequencer.sv
// Triangle-list sequencer: walks a list of packed triangle entries in memory,
// hands each one to the rasterizer and waits for it to finish before fetching
// the next. One entry is in flight at a time.
module triangle_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   tri_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [50:0]       mem_data,
  output logic [7:0]        ax,
  output logic [7:0]        ay,
  output logic [7:0]        bx,
  output logic [7:0]        by,
  output logic [7:0]        cx,
  output logic [7:0]        cy,
  output logic [2:0]        colour,
  output logic              draw_en,
  input  logic              draw_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   tri_index
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_ARM, S_WAIT, S_FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   IDX_ONE  = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [50:0]       vert_q, vert_d;
  logic [ADDR_W:0]   idx_inc;

  assign idx_inc = idx_q + IDX_ONE;

  // State and datapath registers; reset is synchronous and wins over everything.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      vert_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      vert_q  <= vert_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (tri_count == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH:  state_d = S_ISSUE;
      S_ISSUE:  state_d = S_ARM;
      // Rasterizer still reports idle on the cycle after draw_en, so skip it.
      S_ARM:    state_d = S_WAIT;
      S_WAIT:   if (draw_done) state_d = (idx_inc == count_q) ? S_FINISH : S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates: capture on accepted start, latch entry, advance on completion.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    idx_d   = idx_q;
    vert_d  = vert_q;
    case (state_q)
      S_IDLE: begin
        // A zero-length list leaves the previous tri_index visible.
        if (start && tri_count != '0) begin
          addr_d  = base_addr;
          count_d = tri_count;
          idx_d   = '0;
        end
      end
      S_LATCH: vert_d = mem_data;
      S_WAIT: begin
        if (draw_done) begin
          idx_d  = idx_inc;
          addr_d = addr_q + ADDR_ONE; // wraps naturally at 2^ADDR_W
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_rd  = (state_q == S_FETCH);
    draw_en = (state_q == S_ISSUE);
    done    = (state_q == S_FINISH);
    busy    = (state_q != S_IDLE);
  end

  assign mem_addr  = addr_q;
  assign tri_index = idx_q;
  assign colour    = vert_q[50:48];
  assign ax        = vert_q[47:40];
  assign ay        = vert_q[39:32];
  assign bx        = vert_q[31:24];
  assign by        = vert_q[23:16];
  assign cx        = vert_q[15:8];
  assign cy        = vert_q[7:0];

endmodule

// File: tb/tb_triangle_sequencer.sv
// Scoreboard bench for triangle_sequencer: a stimulus process builds expected
// read addresses, issued triangles and final counts from the list memory;
// a monitor process checks them as the DUT presents mem_rd/draw_en/done.
module tb_triangle_sequencer;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   tri_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [50:0]       mem_data;
  logic [7:0]        ax, ay, bx, by, cx, cy;
  logic [2:0]        colour;
  logic              draw_en;
  logic              draw_done;
  logic              busy, done;
  logic [ADDR_W:0]   tri_index;

  triangle_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
    .tri_count(tri_count), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .colour(colour), .draw_en(draw_en), .draw_done(draw_done), .busy(busy),
    .done(done), .tri_index(tri_index)
  );

  always #5 clock = ~clock;

  // List memory: one-cycle read latency.
  logic [50:0] mem [DEPTH];
  always @(posedge clock) if (mem_rd) mem_data <= mem[mem_addr];

  // Rasterizer stand-in: busy for rast_len cycles after each draw_en.
  int         rast_len;
  logic [4:0] rcnt;
  always @(posedge clock) begin
    if (!resetn)      rcnt <= '0;
    else if (draw_en) rcnt <= 5'(rast_len);
    else if (rcnt != 0) rcnt <= rcnt - 5'd1;
  end
  assign draw_done = (rcnt == 0);

  wire [50:0] out_vec = {colour, ax, ay, bx, by, cx, cy};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  int          exp_addr [$];
  logic [50:0] exp_vec  [$];
  int          exp_done [$];
  int          done_cnt = 0;
  int          de_cnt   = 0;
  bit          mon_en   = 0;
  bit          hold_on  = 0;
  logic [50:0] hold_vec;
  int          prev_idx = 0;

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clock) begin
    if (resetn && mon_en) begin
      if (mem_rd) begin
        hold_on = 0;
        chk("rd_expected", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
      end
      if (draw_en) begin
        de_cnt++;
        chk("draw_expected", 64'(exp_vec.size() != 0), 64'd1);
        if (exp_vec.size() != 0) begin
          hold_vec = exp_vec.pop_front();
          chk("vertices", 64'(out_vec), 64'(hold_vec));
          hold_on = 1;
        end
      end else if (done) begin
        hold_on = 0;
        done_cnt++;
        chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) chk("tri_index_at_done", 64'(tri_index), 64'(exp_done.pop_front()));
        chk("busy_in_finish", 64'(busy), 64'd1);
      end else if (hold_on && !mem_rd) begin
        chk("vert_hold", 64'(out_vec), 64'(hold_vec));
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, draw_en, mem_rd, mem_addr, tri_index}), 64'd0);
    chk({tag, "_vert"}, 64'(out_vec), 64'd0);
  endtask

  // Issue one list; abort_de>0 resets the DUT mid-WAIT after that many draws.
  task automatic run_list(input int base, input int cnt, input int lo, input int hi,
                          input bit poke, input int abort_de);
    int target, de0, ab_wait;
    target  = done_cnt + 1;
    ab_wait = 0;
    for (int w = 0; w < 50 && busy; w++) @(negedge clock);
    chk("idle_before_start", 64'(busy), 64'd0);
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_vec.push_back(mem[(base + i) % DEPTH]);
    end
    exp_done.push_back(cnt == 0 ? prev_idx : cnt);
    if (cnt != 0) prev_idx = cnt;
    de0       = de_cnt;
    rast_len  = $urandom_range(hi, lo);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    tri_count = (ADDR_W+1)'(cnt);
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      start     = 1'b0;
      base_addr = ADDR_W'($urandom);
      tri_count = (ADDR_W+1)'($urandom);
      rast_len  = $urandom_range(hi, lo);
      if (done_cnt >= target) break;
      if (abort_de > 0 && de_cnt - de0 >= abort_de) begin
        ab_wait++;
        if (ab_wait == 3) begin
          mon_en = 0;
          resetn = 1'b0;
          @(negedge clock);
          check_reset_outs("midreset");
          exp_addr.delete();
          exp_vec.delete();
          exp_done.delete();
          hold_on  = 0;
          prev_idx = 0;
          resetn   = 1'b1;
          mon_en   = 1;
          return;
        end
      end
      if (poke && busy && $urandom_range(3) == 0) start = 1'b1;
    end
    start = 1'b0;
    chk("list_done", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    logic [63:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      r = {$urandom(), $urandom()};
      mem[i] = r[50:0];
    end
    mem[5] = {3'd3, 8'd10, 8'd10, 8'd20, 8'd10, 8'd10, 8'd20};
    resetn = 1'b0; start = 1'b0; base_addr = '0; tri_count = '0; rast_len = 0;
    repeat (3) @(negedge clock);
    check_reset_outs("reset");
    resetn = 1'b1;
    mon_en = 1;

    run_list(0, 0, 0, 0, 0, 0);        // empty list: no reads, no draws
    run_list(5, 1, 8, 8, 0, 0);        // single known entry, long draw
    run_list(62, 3, 0, 4, 0, 0);       // address wrap 62, 63, 0
    run_list(20, 2, 6, 9, 1, 0);       // start pokes while busy are ignored
    run_list(30, 4, 12, 12, 0, 2);     // reset during WAIT of entry 2
    @(negedge clock);
    check_reset_outs("post_reset");
    run_list(7, 1, 3, 3, 0, 0);        // runs normally after reset
    for (int k = 0; k < 12; k++)
      run_list($urandom_range(DEPTH-1), $urandom_range(6, 1), 0, 6, 1, 0);
    // tri_index holds after the list finishes
    repeat (3) @(negedge clock);
    chk("tri_index_hold", 64'(tri_index), 64'(prev_idx));
    chk("queues_empty", 64'(exp_addr.size() + exp_vec.size() + exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
